task_scheduler: RTL and testbench
=================================

# task_scheduler

Sequences a chain of node-level task blocks (sink check, aggregation, and similar) that share one 2048-word data memory, and arbitrates that memory's single port between them. Runs the tasks strictly in index order. For each task it drives the block's en/start/done handshake and grants the memory port to that task alone. Sits between the node top level, which issues one run per round, and the task blocks plus data memory.

## Interface
- NUM_TASKS, 4, number of task slots, 1..8
- IDX_WIDTH, 3, width of the task index
- WDOG_CYCLES, 1024, WAIT-state cycle limit per task (used only with the watchdog)
- clock  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- run  in  1  start a scheduling round; sampled in IDLE only
- task_mask  in  NUM_TASKS  bit i = 1 runs task i; sampled per task in SELECT
- busy  out  1  round in progress
- sched_done  out  1  round complete; held until the next accepted run
- cur_task  out  IDX_WIDTH  index of the task being visited
- task_err  out  NUM_TASKS  watchdog abort flags
- task_en  out  NUM_TASKS  one-cycle re-arm pulse to task i
- task_start  out  NUM_TASKS  one-cycle start pulse to task i
- task_done  in  NUM_TASKS  level done from task i
- task_addr  in  11*NUM_TASKS  address from each task; flattened
- task_wr_en  in  NUM_TASKS  write enable from each task
- task_wdata  in  16*NUM_TASKS  write data from each task; flattened
- task_rdata  out  16  memory read data, broadcast to all tasks
- mem_address  out  11  to memory
- mem_wr_en  out  1  to memory
- mem_wdata  out  16  to memory
- mem_rdata  in  16  from memory

## Operation
- States: IDLE, SELECT, ARM, START, WAIT, FINISH.
- **IDLE**
  - run=1: go to SELECT, cur_task=0, clear sched_done and task_err.
  - Otherwise stay in IDLE.
- **SELECT**
  - task_mask[cur_task]=0: cur_task+1, or FINISH if cur_task=NUM_TASKS-1. A skipped task costs 1 cycle.
  - task_mask[cur_task]=1: go to ARM.
- **ARM**: task_en[cur_task]=1 for exactly this cycle, then START.
- **START**: task_start[cur_task]=1 for exactly this cycle, then WAIT.
- **WAIT**: hold until task_done[cur_task]=1, then advance as in SELECT's skip rule (next SELECT or FINISH).
- **FINISH**: sched_done=1, busy=0, go to IDLE.
- busy=1 in SELECT, ARM, START and WAIT.
- task_en/task_start are decoded from state and cur_task; all other bits stay 0.
- **Grant**
  - In ARM, START and WAIT, the memory outputs are a pure combinational mux of cur_task's task_addr/task_wr_en/task_wdata.
  - In IDLE, SELECT and FINISH: mem_address=0, mem_wr_en=0, mem_wdata=0.
  - task_wr_en from non-granted tasks is ignored.
- task_rdata = mem_rdata at all times.
- done lines of non-current tasks are ignored. Stale done from a previous round is cleared by the ARM pulse before WAIT samples.
- run while busy: ignored, no queuing.

## Timing
- Reset values: busy=0, sched_done=0, cur_task=0, task_err=0, task_en=0, task_start=0, mem_address=0, mem_wr_en=0, mem_wdata=0; state IDLE.
- run sampled at edge T0 → SELECT at T1, ARM at T2, START at T3, WAIT from T4.
- task_done seen at edge Tk → next SELECT (or FINISH) at Tk+1.
- Last task done at Tk → FINISH at Tk+1, sched_done=1 from Tk+2 onward.
- Overhead per run task: 3 cycles plus the task's own latency.
- Reset mid-round: everything returns to reset values on the next edge and the grant drops immediately. Task blocks are reset by their own nrst.

## Configuration
- TASK_SCHED_WATCHDOG_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches WDOG_CYCLES-1 with no done: set task_err[cur_task], drop the grant, advance as for done.
  - task_err holds until the next accepted run.
- Not defined: WAIT waits indefinitely, task_err tied to 0, no counter logic.

## Test plan
- mask=4'b1111, each task raises done 3 cycles after its start → en/start pulses in order 0..3, sched_done high 25 cycles after run, busy low after.
- mask=4'b1010 → only tasks 1 and 3 get en/start, skips cost 1 cycle each, tasks 0 and 2 never see pulses.
- Task 2 granted, task 0 drives wr_en=1, addr=0x2, data=0x1 → mem_wr_en=0; task 2 writes 0x5 at 0x7 → mem_address=0x7, mem_wdata=0x5, mem_wr_en=1.
- run pulsed again during WAIT of task 1 → ignored, round finishes normally, only one sched_done.
- nrst low during task 1 WAIT → next edge: busy=0, mem_wr_en=0, all outputs at reset values; new run restarts at task 0.
- Watchdog build, WDOG_CYCLES=16, task 2 never asserts done → task_err=4'b0100 after 16 WAIT cycles, task 3 still runs, sched_done asserted.

Source files
------------

// File: rtl/task_scheduler.sv
// task_scheduler: runs masked node task blocks in index order and grants the shared
// 2048-word data-memory port to the active task. Optional watchdog: TASK_SCHED_WATCHDOG_EN.

// Per-slot decode: en/start pulses and the gated memory request of one task.
module task_scheduler_slot (
    input  logic        sel,
    input  logic        arm_st,
    input  logic        start_st,
    input  logic        grant_on,
    input  logic [10:0] req_addr,
    input  logic        req_wr_en,
    input  logic [15:0] req_wdata,
    output logic        en,
    output logic        start,
    output logic [10:0] gnt_addr,
    output logic        gnt_wr_en,
    output logic [15:0] gnt_wdata
);
    logic gnt;

    assign gnt       = sel & grant_on;
    assign en        = sel & arm_st;
    assign start     = sel & start_st;
    assign gnt_addr  = gnt ? req_addr : 11'd0;
    assign gnt_wr_en = gnt & req_wr_en;
    assign gnt_wdata = gnt ? req_wdata : 16'd0;
endmodule

module task_scheduler #(
    parameter int NUM_TASKS   = 4,
    parameter int IDX_WIDTH   = 3,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    nrst,
    input  logic                    run,
    input  logic [NUM_TASKS-1:0]    task_mask,
    output logic                    busy,
    output logic                    sched_done,
    output logic [IDX_WIDTH-1:0]    cur_task,
    output logic [NUM_TASKS-1:0]    task_err,
    output logic [NUM_TASKS-1:0]    task_en,
    output logic [NUM_TASKS-1:0]    task_start,
    input  logic [NUM_TASKS-1:0]    task_done,
    input  logic [11*NUM_TASKS-1:0] task_addr,
    input  logic [NUM_TASKS-1:0]    task_wr_en,
    input  logic [16*NUM_TASKS-1:0] task_wdata,
    output logic [15:0]             task_rdata,
    output logic [10:0]             mem_address,
    output logic                    mem_wr_en,
    output logic [15:0]             mem_wdata,
    input  logic [15:0]             mem_rdata
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_START,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_TASK = IDX_WIDTH'(NUM_TASKS - 1);

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] cur_task_q, cur_task_d;
    logic                 sched_done_q, sched_done_d;
    logic                 cur_mask, cur_done, timeout, advance, grant_on;

    logic [NUM_TASKS-1:0][10:0] gnt_addr;
    logic [NUM_TASKS-1:0]       gnt_wr_en;
    logic [NUM_TASKS-1:0][15:0] gnt_wdata;

    always_comb begin
        cur_mask = 1'b0;
        cur_done = 1'b0;
        for (int i = 0; i < NUM_TASKS; i++) begin
            if (cur_task_q == IDX_WIDTH'(i)) begin
                cur_mask = task_mask[i];
                cur_done = task_done[i];
            end
        end
    end

`ifdef TASK_SCHED_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [15:0]          wdog_q, wdog_d;
    logic [NUM_TASKS-1:0] task_err_q, task_err_d;

    // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
    assign timeout = (state_q == S_WAIT) && !cur_done && (wdog_q == WDOG_LAST);

    always_comb begin
        wdog_d     = (state_q == S_WAIT) ? wdog_q + 16'd1 : 16'd0;
        task_err_d = task_err_q;
        if (state_q == S_IDLE && run) begin
            task_err_d = '0;
        end
        for (int i = 0; i < NUM_TASKS; i++) begin
            if (timeout && cur_task_q == IDX_WIDTH'(i)) begin
                task_err_d[i] = 1'b1;
            end
        end
    end

    assign task_err = task_err_q;
`else
    logic [31:0] wdog_unused;

    assign wdog_unused = WDOG_CYCLES;
    assign timeout     = 1'b0;
    assign task_err    = '0;
`endif

    assign advance = (state_q == S_WAIT) && (cur_done || timeout);

    always_comb begin
        state_d      = state_q;
        cur_task_d   = cur_task_q;
        sched_done_d = sched_done_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d      = S_SELECT;
                    cur_task_d   = '0;
                    sched_done_d = 1'b0;
                end
            end
            S_SELECT: begin
                if (cur_mask) begin
                    state_d = S_ARM;
                end else if (cur_task_q == LAST_TASK) begin
                    state_d = S_FINISH;
                end else begin
                    cur_task_d = cur_task_q + 1'b1;
                end
            end
            S_ARM:   state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (advance) begin
                    if (cur_task_q == LAST_TASK) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d    = S_SELECT;
                        cur_task_d = cur_task_q + 1'b1;
                    end
                end
            end
            S_FINISH: begin
                state_d      = S_IDLE;
                sched_done_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            cur_task_q   <= '0;
            sched_done_q <= 1'b0;
`ifdef TASK_SCHED_WATCHDOG_EN
            wdog_q       <= '0;
            task_err_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cur_task_q   <= cur_task_d;
            sched_done_q <= sched_done_d;
`ifdef TASK_SCHED_WATCHDOG_EN
            wdog_q       <= wdog_d;
            task_err_q   <= task_err_d;
`endif
        end
    end

    // Grant is gated by nrst too so it drops in the same cycle reset is asserted.
    assign grant_on = nrst && ((state_q == S_ARM) || (state_q == S_START) || (state_q == S_WAIT));

    for (genvar i = 0; i < NUM_TASKS; i++) begin : g_slot
        task_scheduler_slot u_slot (
            .sel       (cur_task_q == IDX_WIDTH'(i)),
            .arm_st    (state_q == S_ARM),
            .start_st  (state_q == S_START),
            .grant_on  (grant_on),
            .req_addr  (task_addr[i*11 +: 11]),
            .req_wr_en (task_wr_en[i]),
            .req_wdata (task_wdata[i*16 +: 16]),
            .en        (task_en[i]),
            .start     (task_start[i]),
            .gnt_addr  (gnt_addr[i]),
            .gnt_wr_en (gnt_wr_en[i]),
            .gnt_wdata (gnt_wdata[i])
        );
    end

    // At most one slot is granted, so OR-ing the gated requests forms the mux.
    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        for (int i = 0; i < NUM_TASKS; i++) begin
            mem_address = mem_address | gnt_addr[i];
            mem_wdata   = mem_wdata | gnt_wdata[i];
        end
    end

    assign mem_wr_en  = |gnt_wr_en;
    assign task_rdata = mem_rdata;
    assign busy       = (state_q == S_SELECT) || (state_q == S_ARM) ||
                        (state_q == S_START) || (state_q == S_WAIT);
    assign sched_done = sched_done_q;
    assign cur_task   = cur_task_q;
endmodule

// File: tb/tb_task_scheduler.sv
// Bench for task_scheduler: emulated task blocks with random latencies and memory
// traffic, checked cycle by cycle against a round-level timing model.
`timescale 1ns/1ps
module tb_task_scheduler;
    localparam int NT = 4;
    localparam int IW = 3;
    localparam int WD = 16;

    logic             clock = 1'b0;
    logic             nrst, run;
    logic [NT-1:0]    task_mask, task_done, task_wr_en;
    logic [11*NT-1:0] task_addr;
    logic [16*NT-1:0] task_wdata;
    logic [15:0]      mem_rdata;
    logic             busy, sched_done, mem_wr_en;
    logic [IW-1:0]    cur_task;
    logic [NT-1:0]    task_err, task_en, task_start;
    logic [15:0]      task_rdata, mem_wdata;
    logic [10:0]      mem_address;

    int          n_cmp, n_bad;
    int          lat[NT];
    bit          never[NT];
    int          rem[NT];
    logic [10:0] r_addr[NT];
    logic        r_we[NT];
    logic [15:0] r_wd[NT];
    bit          dir_grant;

    task_scheduler #(.NUM_TASKS(NT), .IDX_WIDTH(IW), .WDOG_CYCLES(WD)) dut (
        .clock(clock), .nrst(nrst), .run(run), .task_mask(task_mask),
        .busy(busy), .sched_done(sched_done), .cur_task(cur_task),
        .task_err(task_err), .task_en(task_en), .task_start(task_start),
        .task_done(task_done), .task_addr(task_addr), .task_wr_en(task_wr_en),
        .task_wdata(task_wdata), .task_rdata(task_rdata),
        .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Task blocks: en clears done, start loads latency, done is a held level.
    task automatic tasks_react();
        for (int i = 0; i < NT; i++) begin
            if (task_en[i]) begin
                task_done[i] = 1'b0;
                rem[i] = 0;
            end else if (task_start[i]) begin
                rem[i] = never[i] ? -1 : lat[i];
            end else if (rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) task_done[i] = 1'b1;
            end
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NT; i++) begin
            r_addr[i] = 11'($urandom);
            r_we[i]   = 1'($urandom);
            r_wd[i]   = 16'($urandom);
        end
        if (dir_grant) begin
            r_we[0] = 1'b1; r_addr[0] = 11'h2; r_wd[0] = 16'h1;
            r_we[2] = 1'b1; r_addr[2] = 11'h7; r_wd[2] = 16'h5;
        end
        for (int i = 0; i < NT; i++) begin
            task_addr[i*11 +: 11]  = r_addr[i];
            task_wr_en[i]          = r_we[i];
            task_wdata[i*16 +: 16] = r_wd[i];
        end
        mem_rdata = 16'($urandom);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sched_done"}, 32'(sched_done), 32'd0);
        chk({tag, "_cur_task"}, 32'(cur_task), 32'd0);
        chk({tag, "_task_err"}, 32'(task_err), 32'd0);
        chk({tag, "_task_en"}, 32'(task_en), 32'd0);
        chk({tag, "_task_start"}, 32'(task_start), 32'd0);
        chk({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        chk({tag, "_mem_wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    // Model: a run task occupies SELECT+ARM+START plus its WAIT cycles, a skip 1 cycle.
    task automatic run_round(input logic [NT-1:0] mask, input int run_again,
                             input int rst_at, input bit check_latency);
        int sel_c[NT], en_c[NT], st_c[NT], we_c[NT];
        bit err_e[NT];
        int t, w, fin, first_sd, g, cur;
        logic [NT-1:0] e_en, e_st, e_err;
        logic [10:0] e_addr;
        logic        e_we;
        logic [15:0] e_wd;

        t = 1;
        for (int i = 0; i < NT; i++) begin
            sel_c[i] = t;
            err_e[i] = 1'b0;
            if (mask[i]) begin
                w = never[i] ? (1 << 30) : lat[i];
`ifdef TASK_SCHED_WATCHDOG_EN
                if (w > WD) begin
                    w = WD;
                    err_e[i] = 1'b1;
                end
`endif
                en_c[i] = t + 1;
                st_c[i] = t + 2;
                we_c[i] = t + 2 + w;
                t = t + 3 + w;
            end else begin
                en_c[i] = -1;
                st_c[i] = -1;
                we_c[i] = -2;
                t = t + 1;
            end
        end
        fin = t;

        task_mask = mask;
        run = 1'b1;
        drive_reqs();
        tick();
        run = 1'b0;
        first_sd = -1;
        for (int c = 1; c <= fin + 3; c++) begin
            tasks_react();
            drive_reqs();
            run = (c == run_again);
            if (c == rst_at) begin
                task_wr_en = '1;
                nrst = 1'b0;
                #1;
                chk("rst_grant_wr_en", 32'(mem_wr_en), 32'd0);
                chk("rst_grant_addr", 32'(mem_address), 32'd0);
                tick();
                chk_reset_vals("midreset");
                for (int i = 0; i < NT; i++) begin
                    task_done[i] = 1'b0;
                    rem[i] = 0;
                end
                run = 1'b0;
                nrst = 1'b1;
                return;
            end
            #1;
            e_en = '0; e_st = '0; e_err = '0; g = -1; cur = 0;
            for (int i = 0; i < NT; i++) begin
                if (en_c[i] == c) e_en[i] = 1'b1;
                if (st_c[i] == c) e_st[i] = 1'b1;
                if (en_c[i] >= 0 && c >= en_c[i] && c <= we_c[i]) g = i;
                if (sel_c[i] <= c) cur = i;
                if (err_e[i] && c > we_c[i]) e_err[i] = 1'b1;
            end
            e_addr = (g >= 0) ? r_addr[g] : 11'd0;
            e_we   = (g >= 0) ? r_we[g] : 1'b0;
            e_wd   = (g >= 0) ? r_wd[g] : 16'd0;
            chk("busy", 32'(busy), 32'(c < fin));
            chk("sched_done", 32'(sched_done), 32'(c > fin));
            chk("task_en", 32'(task_en), 32'(e_en));
            chk("task_start", 32'(task_start), 32'(e_st));
            chk("task_err", 32'(task_err), 32'(e_err));
            if (c < fin) chk("cur_task", 32'(cur_task), 32'(cur));
            chk("mem_address", 32'(mem_address), 32'(e_addr));
            chk("mem_wr_en", 32'(mem_wr_en), 32'(e_we));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            chk("task_rdata", 32'(task_rdata), 32'(mem_rdata));
            if (dir_grant && c == st_c[2]) begin
                chk("grant2_addr", 32'(mem_address), 32'h7);
                chk("grant2_wdata", 32'(mem_wdata), 32'h5);
                chk("grant2_wr_en", 32'(mem_wr_en), 32'd1);
            end
            if (first_sd < 0 && sched_done === 1'b1) first_sd = c;
            tick();
        end
        run = 1'b0;
        if (check_latency) chk("sched_done_latency", 32'(first_sd - 1), 32'd25);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nrst = 1'b0;
        run = 1'b0;
        task_mask = '0;
        task_done = '0;
        dir_grant = 1'b0;
        for (int i = 0; i < NT; i++) begin
            lat[i] = 3;
            never[i] = 1'b0;
            rem[i] = 0;
        end
        drive_reqs();
        tick();
        tick();
        chk_reset_vals("reset");
        nrst = 1'b1;
        tick();
        chk_reset_vals("idle");

        // all four tasks, done three cycles after each start
        run_round(4'b1111, -1, -1, 1'b1);

        // sparse mask with random latencies
        for (int i = 0; i < NT; i++) lat[i] = $urandom_range(1, 5);
        run_round(4'b1010, -1, -1, 1'b0);

        // only task 2 granted while task 0 keeps writing
        dir_grant = 1'b1;
        run_round(4'b0100, -1, -1, 1'b0);
        dir_grant = 1'b0;

        // run pulsed during task 1 WAIT (cycles 10..12 with latency 3)
        for (int i = 0; i < NT; i++) lat[i] = 3;
        run_round(4'b1111, 10, -1, 1'b0);

        // reset during task 1 WAIT, then a fresh round from task 0
        run_round(4'b1111, -1, 11, 1'b0);
        run_round(4'b1111, -1, -1, 1'b0);

        // random masks and latencies, including the empty mask
        run_round(4'b0000, -1, -1, 1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NT; i++) lat[i] = $urandom_range(1, 6);
            run_round(4'($urandom), -1, -1, 1'b0);
        end

`ifdef TASK_SCHED_WATCHDOG_EN
        lat[0] = 2; lat[1] = 3; lat[3] = 2;
        never[2] = 1'b1;
        run_round(4'b1111, -1, -1, 1'b0);
        chk("wdog_task_err", 32'(task_err), 32'h4);
        chk("wdog_sched_done", 32'(sched_done), 32'd1);
        never[2] = 1'b0;
        lat[2] = WD;
        run_round(4'b0100, -1, -1, 1'b0);
        chk("wdog_edge_err", 32'(task_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
